// File: rtl/jk_reg_bank.sv
// WIDTH-bit JK register bank with load, up/down count and optional sticky change flags (JK_REG_BANK_CHG_FLAG_EN).
// Latency: q one edge after inputs; qb/tc combinational from q, en, mode.
// No backpressure: en=0 holds state, and every enabled edge is accepted.
module jk_reg_bank #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  input  logic             chg_clr,
  output logic [WIDTH-1:0] chg
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DN   = 2'b11;

  logic [WIDTH-1:0] tgl;
  logic [WIDTH-1:0] jj;
  logic [WIDTH-1:0] kk;
  logic [WIDTH-1:0] q_nxt;

  // Ripple toggle chain: up toggles above trailing ones, down above trailing zeros.
  always_comb begin
    tgl    = '0;
    tgl[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      if (mode == MODE_DN) tgl[i] = tgl[i-1] & ~q[i-1];
      else                 tgl[i] = tgl[i-1] &  q[i-1];
    end
  end

  // Every mode is expressed as per-bit J/K so a single JK update equation serves all.
  always_comb begin
    jj = j;
    kk = k;
    case (mode)
      MODE_JK:   begin jj = j;   kk = k;   end
      MODE_LOAD: begin jj = d;   kk = ~d;  end
      default:   begin jj = tgl; kk = tgl; end
    endcase
  end

  assign q_nxt = (jj & ~q) | (~kk & q);

  always_ff @(posedge clk) begin
    if (!rst_n)  q <= RESET_VAL;
    else if (en) q <= q_nxt;
  end

  assign qb = ~q;
  assign tc = en & (((mode == MODE_UP) & (&q)) | ((mode == MODE_DN) & ~(|q)));

`ifdef JK_REG_BANK_CHG_FLAG_EN
  logic [WIDTH-1:0] chg_r;
  logic [WIDTH-1:0] chg_set;

  assign chg_set = en ? (q_nxt ^ q) : '0;

  // Set wins over a same-edge clear; clear is honoured even while en=0.
  always_ff @(posedge clk) begin
    if (!rst_n) chg_r <= '0;
    else        chg_r <= chg_set | (chg_clr ? '0 : chg_r);
  end

  assign chg = chg_r;
`else
  logic unused_chg_clr;
  assign unused_chg_clr = chg_clr;
  assign chg = '0;
`endif

endmodule
